data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised, multi-cycle data memory for the RISC processor's memory stage. It accepts one request at a time over a req/ready handshake and supports byte, halfword and word loads and stores with little-endian lane selection. Loads can be sign- or zero-extended. A programmable number of wait states models slower memory, and misaligned, out-of-range or reserved-size requests are flagged without touching storage.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: width of the byte address bus.
- `DEPTH`, default 256: number of 32-bit words of storage; must be a power of two, minimum 4.
- `WAIT_CYCLES`, default 2: extra wait states per valid access; legal range 0..15.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `write`  in  1  1 = store, 0 = load; sampled with `req`.
- `size`  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- `sign_ext`  in  1  load extension: 1 = sign-extend, 0 = zero-extend; ignored for word accesses and stores.
- `address`  in  ADDR_WIDTH  byte address.
- `write_data`  in  32  store data; the byte or halfword is taken from the low bits.
- `read_data`  out  32  load result; holds its value until the next completion.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the accept edge until the end of the DONE cycle.
- `fault`  out  1  high together with `ready` when the completing request was rejected.

## Operation

- Storage is `DEPTH` words. Word index = `address[log2(DEPTH)+1:2]`. The byte lane within a word is `address[1:0]`, lane 0 = bits 7:0.
- State machine has three states: IDLE, WAIT and DONE.
- IDLE:
  - `req`=1 latches `write`, `size`, `sign_ext`, `address` and `write_data`, and sets `busy`.
  - Fault check is performed on the same edge. Any of the following causes a fault:
    - `size`=11;
    - halfword with `address[0]`=1;
    - word with `address[1:0]`≠0;
    - `address[ADDR_WIDTH-1:2]` ≥ `DEPTH`.
  - On a fault: go to DONE with the fault flag set; storage is not accessed.
  - Otherwise: go to WAIT and load the counter with `WAIT_CYCLES`.
- WAIT:
  - If the counter ≠ 0, decrement it.
  - If the counter = 0, perform the access on this edge and go to DONE.
- Store access:
  - Read-modify-write of the addressed word on a single edge.
  - Byte writes lane `address[1:0]` only.
  - Halfword writes lanes {`address[1]`·2+1, `address[1]`·2} only.
  - Word writes all four lanes.
  - `read_data` is set to 0.
- Load access:
  - Select the lane(s) as for stores.
  - Extend to 32 bits according to `sign_ext`.
  - Register the result into `read_data`.
- DONE:
  - `ready`=1 for exactly one cycle; `fault` shows the latched fault flag.
  - On a fault, `read_data` is set to 0.
  - Next state is unconditionally IDLE. `req` held high during DONE is not accepted in that cycle; it is re-sampled in IDLE.
- `req` in WAIT or DONE is ignored; there is no queueing.
- Reset:
  - State goes to IDLE; `ready`=0, `busy`=0, `fault`=0, `read_data`=0, counter=0.
  - Storage contents are not cleared.
- Reset mid-operation (in WAIT or DONE): the request is aborted, no store is performed, and no `ready` pulse is produced. Reset has priority over every other event on the same edge.

## Timing

- Valid access accepted at edge E0:
  - access is performed at edge E0+`WAIT_CYCLES`+1;
  - `ready` is high for the cycle after that edge.
- Load-to-ready latency is `WAIT_CYCLES`+1 cycles after the accept edge.
- Faulted request: `ready`/`fault` are high in the cycle immediately after the accept edge (latency 1, independent of `WAIT_CYCLES`).
- `busy` is high from E0 until the edge that leaves DONE, and is low in IDLE.
- Minimum request spacing: a new request can be accepted on the edge ending DONE+1, i.e. back-to-back throughput is one access per `WAIT_CYCLES`+3 cycles.
- `read_data` changes only on an access edge, a fault completion or reset. It is stable while `ready`=1 and afterwards.
- Out-of-range words are never read, so no X reaches `read_data`.

## Test plan

- Reset, then with `WAIT_CYCLES`=2: store word 0x11223344 to address 0x4, then load word from 0x4.
  - Expect `read_data`=0x11223344 and `ready` 3 cycles after the accept edge.
  - Expect `busy` high for 4 cycles.
- Store byte 0xAA to address 0x5, then load word from 0x4.
  - Expect 0x1122AA44.
- Load byte from 0x5 with `sign_ext`=1 → expect 0xFFFFFFAA. With `sign_ext`=0 → expect 0x000000AA.
- Load halfword from 0x6 with `sign_ext`=1 → expect 0x00001122.
- Fault cases, each giving `ready`=`fault`=1 one cycle after accept and `read_data`=0:
  - load word from 0x2;
  - halfword store to 0x7;
  - `size`=11;
  - address 4·`DEPTH`.
  - A following load from 0x4 is unchanged.
- Start a store of 0xDEADBEEF to 0x8 and assert `reset` during WAIT.
  - Expect no `ready` pulse, all outputs 0, and a later load from 0x8 returns the prior value.
  - A `req` pulse during WAIT of a valid access is ignored, and only one `ready` pulse is produced.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
// ----------------
// Multi-cycle data memory for the memory stage of the RISC core. It accepts
// one request at a time, performs byte/halfword/word loads and stores with
// little-endian lane selection, and inserts WAIT_CYCLES wait states before
// each valid access. Misaligned, out-of-range and reserved-size requests are
// rejected without touching storage and complete one cycle after acceptance.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   req         request strobe, sampled only in IDLE
//   write       1 = store, 0 = load (sampled with req)
//   size        00 byte, 01 halfword, 10 word, 11 reserved
//   sign_ext    1 = sign-extend sub-word loads, 0 = zero-extend
//   address     byte address
//   write_data  store data, byte/halfword taken from the low bits
//   read_data   load result, held until the next completion
//   ready       one-cycle completion pulse
//   busy        high from the accept edge until the end of DONE
//   fault       high with ready when the completing request was rejected

module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  write,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  fault
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t            state;
  logic [3:0]        count;

  // Request fields captured on the accept edge.
  logic              lat_write;
  logic [1:0]        lat_size;
  logic              lat_sign;
  logic [IDX_W-1:0]  lat_idx;
  logic [1:0]        lat_lane;
  logic [31:0]       lat_wdata;

  // NOTE: storage is deliberately left out of reset; clearing a RAM array on
  // reset would force it into flops and defeat memory inference.
  logic [31:0]       mem [DEPTH];

  logic [31:0]       mem_word;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_val;
  logic [31:0]       store_val;
  logic              out_of_range;
  logic              req_bad;
  logic              access_now;

  // With DEPTH a power of two, word index >= DEPTH is equivalent to any
  // address bit above the index field being set.
  generate
    if (ADDR_WIDTH > IDX_W + 2) begin : g_range
      assign out_of_range = |address[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign req_bad = out_of_range
                 | (size == 2'b11)
                 | ((size == 2'b01) & address[0])
                 | ((size == 2'b10) & (address[1:0] != 2'b00));

  assign mem_word   = mem[lat_idx];
  assign access_now = (state == ST_WAIT) && (count == 4'd0);

  // Lane selection and merging for the latched request.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    sel_byte  = mem_word[{lat_lane, 3'b000} +: 8];
    sel_half  = lat_lane[1] ? mem_word[31:16] : mem_word[15:0];
    load_val  = mem_word;
    store_val = mem_word;
    case (lat_size)
      2'b00: begin
        load_val = {{24{lat_sign & sel_byte[7]}}, sel_byte};
        store_val[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
      end
      2'b01: begin
        load_val = {{16{lat_sign & sel_half[15]}}, sel_half};
        if (lat_lane[1]) store_val[31:16] = lat_wdata[15:0];
        else             store_val[15:0]  = lat_wdata[15:0];
      end
      default: begin
        // Word access; reserved size never reaches the access edge.
        store_val = lat_wdata;
      end
    endcase
  end

  // Read-modify-write store on the access edge; reset wins over the store.
  always_ff @(posedge clock) begin
    if (!reset && access_now && lat_write) begin
      mem[lat_idx] <= store_val;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= ST_IDLE;
      count     <= 4'd0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      read_data <= 32'd0;
      lat_write <= 1'b0;
      lat_size  <= 2'b00;
      lat_sign  <= 1'b0;
      lat_idx   <= '0;
      lat_lane  <= 2'b00;
      lat_wdata <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_write <= write;
            lat_size  <= size;
            lat_sign  <= sign_ext;
            lat_idx   <= address[IDX_W+1:2];
            lat_lane  <= address[1:0];
            lat_wdata <= write_data;
            busy      <= 1'b1;
            if (req_bad) begin
              // Rejected: complete next cycle without touching storage.
              state     <= ST_DONE;
              ready     <= 1'b1;
              fault     <= 1'b1;
              read_data <= 32'd0;
            end else begin
              state <= ST_WAIT;
              count <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            state     <= ST_DONE;
            ready     <= 1'b1;
            fault     <= 1'b0;
            read_data <= lat_write ? 32'd0 : load_val;
          end
        end
        ST_DONE: begin
          // req is not sampled here; a held req is accepted back in IDLE.
          state <= ST_IDLE;
          ready <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: a directed vector table, a few
// hand-written multi-cycle sequences (reset abort, req during WAIT, held req)
// and randomized traffic compared against a byte-array reference model.

module tb_data_memory_ctrl;

  localparam int AW          = 32;
  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 2;
  // Negedges from the accept edge to the ready cycle for a valid access.
  localparam int VALID_LAT   = WAIT_CYCLES + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          req;
  logic          write;
  logic [1:0]    size;
  logic          sign_ext;
  logic [AW-1:0] address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic          busy;
  logic          fault;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain byte-addressed storage.
  logic [7:0] ref_bytes [4*DEPTH];

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [12];

  data_memory_ctrl #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .write     (write),
    .size      (size),
    .sign_ext  (sign_ext),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Applies a request to the byte model and returns the expected outcome.
  function automatic void model_access(input logic wr, input logic [1:0] sz,
                                       input logic sx, input logic [31:0] ad,
                                       input logic [31:0] wd,
                                       output logic [31:0] rd, output logic flt);
    int nb;
    nb  = 1 << sz;
    flt = (sz == 2'd3) || (sz == 2'd1 && ad[0]) ||
          (sz == 2'd2 && ad[1:0] != 2'd0) || (ad >= 32'(4*DEPTH));
    rd  = 32'd0;
    if (flt) return;
    for (int i = 0; i < nb; i++) begin
      if (wr) ref_bytes[ad + 32'(i)] = wd[8*i +: 8];
      else    rd[8*i +: 8] = ref_bytes[ad + 32'(i)];
    end
    if (!wr && sx && nb < 4 && rd[8*nb-1]) begin
      for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hFF;
    end
  endfunction

  // One complete transaction with timing, handshake and data checks.
  task automatic run_access(input string tag, input logic wr, input logic [1:0] sz,
                            input logic sx, input logic [31:0] ad, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic exp_fault);
    int lat;
    int busy_n;
    int exp_lat;
    exp_lat = exp_fault ? 1 : VALID_LAT;
    @(negedge clock);
    req = 1'b1; write = wr; size = sz; sign_ext = sx; address = ad; write_data = wd;
    @(negedge clock);
    // Scramble inputs so a DUT that fails to latch them is caught.
    req = 1'b0; write = 1'($urandom); address = $urandom; write_data = $urandom;
    sign_ext = 1'($urandom);
    lat = 1;
    busy_n = 0;
    while (!ready && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clock);
      lat++;
    end
    if (!ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: no ready within %0d cycles", tag, lat);
      return;
    end
    if (busy) busy_n++;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    check({tag, " read_data"}, read_data, exp_rd);
    check({tag, " fault"}, 32'(fault), 32'(exp_fault));
    @(negedge clock);
    check({tag, " ready_pulse"}, 32'(ready), 32'd0);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " fault_after"}, 32'(fault), 32'd0);
    check({tag, " read_data_hold"}, read_data, exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] erd;
    logic        ef;
    logic [31:0] wd;
    logic [31:0] ad;
    logic [1:0]  sz;
    logic        wr;
    logic        sx;
    logic [31:0] got;
    int          pulses;
    int          first_k;
    int          second_k;

    reset = 1'b1; req = 1'b0; write = 1'b0; size = 2'b00; sign_ext = 1'b0;
    address = '0; write_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset ready", 32'(ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset read_data", read_data, 32'd0);

    // Directed vectors: {write, size, sign_ext, address, write_data, read_data, fault}
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h4,   32'h11223344, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h4,   32'h0,        32'h1122_3344, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h5,   32'h0000_00AA, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h4,   32'h0,        32'h1122_AA44, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h5,   32'h0,        32'hFFFF_FFAA, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h5,   32'h0,        32'h0000_00AA, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h6,   32'h0,        32'h0000_1122, 1'b0};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h2,   32'h0,        32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h7,   32'h0000_5555, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 2'd3, 1'b0, 32'h4,   32'h9999_9999, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'(4*DEPTH), 32'h0,   32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h4,   32'h0,        32'h1122_AA44, 1'b0};

    for (int v = 0; v < 12; v++) begin
      model_access(vecs[v].wr, vecs[v].sz, vecs[v].sx, vecs[v].ad, vecs[v].wd, erd, ef);
      run_access($sformatf("vec%0d", v), vecs[v].wr, vecs[v].sz, vecs[v].sx,
                 vecs[v].ad, vecs[v].wd, vecs[v].exp_rd, vecs[v].exp_fault);
    end

    // Fill words 0..15 so the model and the DUT agree on every byte used later.
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model_access(1'b1, 2'd2, 1'b0, 32'(w*4), wd, erd, ef);
      run_access($sformatf("init%0d", w), 1'b1, 2'd2, 1'b0, 32'(w*4), wd, erd, ef);
    end

    // Reset lands on the access edge of a store: store aborted, no ready.
    @(negedge clock);
    req = 1'b1; write = 1'b1; size = 2'd2; sign_ext = 1'b0;
    address = 32'h8; write_data = 32'hDEADBEEF;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort ready", 32'(ready), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort fault", 32'(fault), 32'd0);
    check("abort read_data", read_data, 32'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clock);
      if (ready) pulses++;
    end
    check("abort no_ready", 32'(pulses), 32'd0);
    model_access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, erd, ef);
    run_access("abort reload", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, erd, ef);

    // A req pulse during WAIT is ignored: one ready, target word untouched.
    model_access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, erd, ef);
    @(negedge clock);
    req = 1'b1; write = 1'b0; size = 2'd2; sign_ext = 1'b0; address = 32'h8;
    pulses = 0;
    got = 32'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (ready) begin
        pulses++;
        got = read_data;
      end
      if (k == 1) req = 1'b0;
      if (k == 2) begin
        req = 1'b1; write = 1'b1; address = 32'hC; write_data = $urandom;
      end
      if (k == 3) req = 1'b0;
    end
    check("wait_req pulses", 32'(pulses), 32'd1);
    check("wait_req read_data", got, erd);
    model_access(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, erd, ef);
    run_access("wait_req untouched", 1'b0, 2'd2, 1'b0, 32'hC, 32'h0, erd, ef);

    // req held high: DONE does not accept, next accept is one IDLE later.
    model_access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, erd, ef);
    @(negedge clock);
    req = 1'b1; write = 1'b0; size = 2'd2; sign_ext = 1'b0; address = 32'h4;
    pulses = 0;
    first_k = 0;
    second_k = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (ready) begin
        if (pulses == 0) first_k = k;
        else             second_k = k;
        pulses++;
        check($sformatf("held_req read_data%0d", pulses), read_data, erd);
      end
      if (k == 6) req = 1'b0;
    end
    check("held_req pulses", 32'(pulses), 32'd2);
    check("held_req first", 32'(first_k), 32'(VALID_LAT));
    check("held_req spacing", 32'(second_k - first_k), 32'(WAIT_CYCLES + 3));

    // Randomized traffic against the byte model.
    for (int t = 0; t < 150; t++) begin
      wr = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) begin
        ad = $urandom;
        if (ad < 32'(4*DEPTH)) ad = ad + 32'(4*DEPTH);
      end else begin
        ad = 32'($urandom_range(0, 63));
      end
      wd = $urandom;
      model_access(wr, sz, sx, ad, wd, erd, ef);
      run_access($sformatf("rand%0d", t), wr, sz, sx, ad, wd, erd, ef);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
